// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-control encodings for the execute-stage sequencer.
package pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MUL = 2'd1, DRAIN = 2'd2} state_e;
  localparam int MEM_READ_BIT = 1;
endpackage

// File: rtl/mult_seq.sv
// mult_seq: multiply occupancy FSM; holds MUL for MULT_CYCLES-1 cycles, then one DRAIN cycle.
module mult_seq
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic drain
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = start ? MUL : RUN;
    cnt_d   = start ? CNT_W'(MULT_CYCLES - 1) : '0;
    if (state_q == MUL) begin
      state_d = (cnt_q == CNT_W'(1)) ? DRAIN : MUL;
      cnt_d   = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy  = state_q == MUL;
  assign drain = state_q == DRAIN;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: execute-stage sequencing; load-use stall, branch flush and multiply hold.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] IDRegRs,
  input  logic [4:0] IDRegRt,
  input  logic       IDUsesRt,
  input  logic       IDIsMult,
  input  logic       IDEXMemRead,
  input  logic [4:0] IDEXRegRt,
  input  logic       EXBranchTaken,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       MultStart,
  output logic       MultBusy
);
  logic lu, busy, drain, free;
  assign lu = IDEXMemRead & (IDEXRegRt != '0) &
              ((IDEXRegRt == IDRegRs) | (IDUsesRt & (IDEXRegRt == IDRegRt)));
  // DRAIN behaves exactly like RUN for issue decisions
  assign free = drain | ~busy;
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    MultStart  = 1'b0;
    MultBusy   = 1'b0;
    if (reset) begin
    end else if (!free) begin
      MultBusy  = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (EXBranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (lu) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else begin
      MultStart = IDIsMult;
    end
  end
  mult_seq #(.MULT_CYCLES(MULT_CYCLES), .CNT_W(CNT_W)) u_seq (
    .clock(clock),
    .reset(reset),
    .start(MultStart),
    .busy (busy),
    .drain(drain)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks against a remaining-busy-cycles reference model.
module tb_hazard_ctrl;
  localparam int MC = 4;
  logic       clock = 0, reset = 1;
  logic [4:0] IDRegRs = 0, IDRegRt = 0, IDEXRegRt = 0;
  logic       IDUsesRt = 0, IDIsMult = 0, IDEXMemRead = 0, EXBranchTaken = 0;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MultStart, MultBusy;
  int vectors = 0, errs = 0, rem = 0;
  logic [5:0] exp_q;
  hazard_ctrl #(.MULT_CYCLES(MC), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .IDRegRs(IDRegRs), .IDRegRt(IDRegRt),
    .IDUsesRt(IDUsesRt), .IDIsMult(IDIsMult), .IDEXMemRead(IDEXMemRead),
    .IDEXRegRt(IDEXRegRt), .EXBranchTaken(EXBranchTaken), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
    .MultStart(MultStart), .MultBusy(MultBusy)
  );
  always #5 clock = ~clock;
  wire [5:0] outs = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MultStart, MultBusy};
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %b want %b at %0t", tag, got, want, $time);
    end
  endtask
  function automatic logic [5:0] model();
    bit lu_m;
    lu_m = IDEXMemRead && IDEXRegRt != 0 &&
           (IDEXRegRt == IDRegRs || (IDUsesRt && IDEXRegRt == IDRegRt));
    if (reset) return 6'b110000;
    if (rem > 0) return 6'b000001;
    if (EXBranchTaken) return 6'b111100;
    if (lu_m) return 6'b000100;
    if (IDIsMult) return 6'b110010;
    return 6'b110000;
  endfunction
  task automatic set_in(input int rs, input int rt, input bit uses, input bit mult,
                        input bit mr, input int exrt, input bit br, input bit rst);
    IDRegRs = 5'(rs); IDRegRt = 5'(rt); IDUsesRt = uses; IDIsMult = mult;
    IDEXMemRead = mr; IDEXRegRt = 5'(exrt); EXBranchTaken = br; reset = rst;
  endtask
  task automatic settle();
    @(negedge clock);
  endtask
  task automatic tick();
    exp_q = model();
    chk("model", outs, exp_q);
    chk("inv_pc_ifid", {5'b0, PCWrite}, {5'b0, IFIDWrite});
    if (MultBusy) chk("inv_start_in_mul", {5'b0, MultStart}, 6'b0);
    if (IFIDFlush) chk("inv_flush_bubble", {5'b0, IDEXBubble}, 6'b1);
    @(posedge clock);
    if (reset) rem = 0;
    else if (rem > 0) rem--;
    else if (exp_q[1]) rem = MC - 1;
    #1;
  endtask
  initial begin
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    settle(); chk("reset_state", outs, 6'b110000); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1); settle(); tick();
    set_in(5, 0, 0, 0, 1, 5, 0, 0); settle(); chk("lu_stall", outs, 6'b000100); tick();
    set_in(5, 0, 0, 0, 0, 0, 0, 0); settle(); chk("lu_release", outs, 6'b110000); tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0); settle(); chk("zero_reg", outs, 6'b110000); tick();
    set_in(1, 7, 0, 0, 1, 7, 0, 0); settle(); chk("rt_unused", outs, 6'b110000); tick();
    set_in(1, 7, 1, 0, 1, 7, 0, 0); settle(); chk("rt_used", outs, 6'b000100); tick();
    set_in(5, 0, 0, 1, 1, 5, 1, 0); settle(); chk("branch_over_lu", outs, 6'b111100); tick();
    set_in(1, 2, 0, 0, 0, 0, 0, 0); settle(); chk("no_stall_after_br", outs, 6'b110000); tick();
    set_in(1, 2, 0, 1, 0, 0, 0, 0); settle(); chk("mult_start", outs, 6'b110010); tick();
    for (int i = 0; i < MC - 1; i++) begin
      set_in(1, 2, 0, 1, 1, 1, 1, 0); settle(); chk("mult_busy", outs, 6'b000001); tick();
    end
    set_in(1, 2, 0, 1, 0, 0, 0, 0); settle(); chk("drain_restart", outs, 6'b110010); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("busy_again", outs, 6'b000001); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1); settle(); chk("reset_mid_mul", outs, 6'b110000); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("after_reset", outs, 6'b110000); tick();
    settle(); chk("no_drain_start", outs, 6'b110000); tick();
    for (int i = 0; i < 10000; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      settle(); tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the execute stage.
- Decides each cycle whether the front end advances, stalls, or flushes.
- Drives PC write-enable, IF/ID write-enable and flush, and the ID/EX bubble (control fields forced to zero).
- Owns a multi-cycle multiply sequencer: the execute-stage multiplier is busy for MULT_CYCLES, and this block holds the pipeline until the result is ready.

Parameters:
MULT_CYCLES, 4, total cycles a multiply occupies EX (legal range 2..16)
CNT_W, 4, width of the busy down-counter (must satisfy 2^CNT_W > MULT_CYCLES)

Ports:
clock  in  1  pipeline clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
IDRegRs  in  5  rs field of the instruction in ID
IDRegRt  in  5  rt field of the instruction in ID
IDUsesRt  in  1  ID instruction reads rt as a source
IDIsMult  in  1  ID instruction is a multiply
IDEXMemRead  in  1  instruction in EX is a load (ID/EX M field, bit 1)
IDEXRegRt  in  5  destination rt of the instruction in EX
EXBranchTaken  in  1  branch resolved taken in EX this cycle
PCWrite  out  1  1 = PC updates
IFIDWrite  out  1  1 = IF/ID register updates
IFIDFlush  out  1  1 = IF/ID loads a NOP
IDEXBubble  out  1  1 = ID/EX WB/M/EX control fields load zero
MultStart  out  1  one-cycle pulse: multiplier latches operands
MultBusy  out  1  multiplier occupied; result not yet valid

Behaviour:
States (2-bit, registered): RUN=0, MUL=1, DRAIN=2.

Reset:
- Synchronous: state=RUN, counter=0.
- While reset is high, outputs are PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, MultStart=0, MultBusy=0.
- Reset mid-multiply abandons the operation: no MultStart and no DRAIN follows.

Load-use hazard (lu), combinational:
- lu = IDEXMemRead & (IDEXRegRt != 0) & ((IDEXRegRt == IDRegRs) | (IDUsesRt & (IDEXRegRt == IDRegRt))).

Output priority in RUN (highest first):
1. EXBranchTaken: IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1. Any lu or IDIsMult in ID is discarded; no MultStart.
2. lu: PCWrite=0, IFIDWrite=0, IDEXBubble=1. The stall lasts exactly 1 cycle; the next cycle re-evaluates with the bubble in EX.
3. IDIsMult: MultStart=1, PCWrite=1, IFIDWrite=1 (the multiply enters EX). Next state MUL, counter<=MULT_CYCLES-1.
4. Otherwise all enables 1, flush/bubble 0.

MUL:
- MultBusy=1, PCWrite=0, IFIDWrite=0, IDEXBubble=0.
- ID/EX is held, not bubbled: the holding is by the pipeline, and this block does not assert bubble.
- Counter decrements each cycle. When the counter reaches 1, next state is DRAIN.
- EXBranchTaken is ignored in MUL, because a multiply is never a branch.

DRAIN:
- 1 cycle. MultBusy=0; the result is valid for forwarding.
- Outputs are computed exactly as in RUN (same priority list); next state follows RUN rules.
- Back-to-back multiplies are therefore legal.

Latency:
- Multiply issued at cycle t: MultBusy is high on cycles t+1 .. t+MULT_CYCLES-1; the pipeline resumes at t+MULT_CYCLES.

Invariants:
- MultStart is never high in state MUL.
- IFIDFlush implies IDEXBubble.
- PCWrite == IFIDWrite in every cycle.

Decomposition:
- Shared package pipe_pkg: state encodings RUN/MUL/DRAIN and ID/EX M-field bit index MEM_READ_BIT=1.
- Sub-module mult_seq: the MUL/DRAIN FSM and down-counter, with inputs start and reset and outputs busy and drain.
- Hazard compare and priority mux stay in the top level.

Test Plan:
1. Load-use: EX has lw with IDEXRegRt=5; ID has add with IDRegRs=5 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1, then all enables 1.
2. $zero and rt-unused cases:
   - IDEXRegRt=0, IDRegRs=0, IDEXMemRead=1 -> no stall.
   - IDEXRegRt=7, IDRegRt=7, IDUsesRt=0 -> no stall.
3. Branch over hazard: EXBranchTaken=1 together with lu=1 -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; no stall cycle follows.
4. Multiply, MULT_CYCLES=4: IDIsMult at cycle 10 -> MultStart at 10; MultBusy and PCWrite=0 on cycles 11-13; DRAIN at 14 with PCWrite=1. A second IDIsMult at 14 -> MultStart at 14.
5. Reset mid-multiply: reset at cycle 12 -> at 13 state=RUN, MultBusy=0, PCWrite=1; no DRAIN pulse.
6. Random stimulus, 10k cycles: invariant assertions hold (PCWrite==IFIDWrite, flush implies bubble, no MultStart in MUL).
